seq_addsub_n: RTL and testbench

- Parametrised multi-cycle two's-complement adder/subtractor for the calculator datapath.
- Generalises the fixed 8-bit add-only unit in three ways: configurable operand width, configurable bits-per-cycle ripple chunking, and selectable overflow policy.
- Adds subtraction, a busy/done handshake, and overflow and carry flags.
- Sits between the operand registers and the result/display logic; it is driven by the calculator control FSM.

---
 rtl/seq_addsub_n.sv | 147 ++++++++++++++
 tb/tb_seq_addsub_n.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_addsub_n.sv
// seq_addsub_n: multi-cycle two's-complement adder/subtractor.
// The operands are captured on the accepting edge. They are then summed
// CHUNK bits per cycle through a ripple of full-adder cells. When the last
// chunk is done, the overflow policy selected by OVF_MODE is applied to the
// result.
module seq_addsub_n #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CHUNK    = 4,
    parameter int unsigned OVF_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             overflow_o,
    output logic             carry_out_o
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [WIDTH-1:0]   op_b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               carry_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               overflow_q;
    logic               carry_out_q;

    // Next-state values produced by the chunk adder and the overflow policy
    int unsigned        base_s;
    logic [CHUNK:0]     chain_s;
    logic [WIDTH-1:0]   sum_d;
    logic               carry_d;
    logic               ovf_d;
    logic [WIDTH-1:0]   result_d;

    // Ripple of CHUNK full-adder cells over the current chunk, merged into the partial sum
    always_comb begin
        base_s     = int'(idx_q) * CHUNK;
        sum_d      = sum_q;
        chain_s    = {(CHUNK+1){1'b0}};
        chain_s[0] = carry_q;
        for (int k = 0; k < int'(CHUNK); k++) begin
            sum_d[base_s + k] = op_a_q[base_s + k] ^ op_b_q[base_s + k] ^ chain_s[k];
            chain_s[k+1]      = (op_a_q[base_s + k] & op_b_q[base_s + k]) |
                                (chain_s[k] & (op_a_q[base_s + k] ^ op_b_q[base_s + k]));
        end
        carry_d = chain_s[CHUNK];
    end

    // Signed overflow detection and the result substitution chosen by OVF_MODE
    always_comb begin
        ovf_d = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (sum_d[WIDTH-1] != op_a_q[WIDTH-1]);
        if (ovf_d) begin
            case (OVF_MODE)
                32'd0:   result_d = {WIDTH{1'b0}};
                32'd1:   result_d = op_a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
                default: result_d = sum_d;
            endcase
        end else begin
            result_d = sum_d;
        end
    end

    // Control FSM: operand capture, chunk sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_a_q      <= {WIDTH{1'b0}};
            op_b_q      <= {WIDTH{1'b0}};
            sum_q       <= {WIDTH{1'b0}};
            carry_q     <= 1'b0;
            idx_q       <= {IDX_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {WIDTH{1'b0}};
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        // Subtraction is a + ~b + 1: invert b and seed the carry with sub
                        op_a_q  <= a_i;
                        op_b_q  <= b_i ^ {WIDTH{sub_i}};
                        carry_q <= sub_i;
                        sum_q   <= {WIDTH{1'b0}};
                        idx_q   <= {IDX_W{1'b0}};
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        result_q    <= result_d;
                        overflow_q  <= ovf_d;
                        carry_out_q <= carry_d;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= S_RUN;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign overflow_o  = overflow_q;
    assign carry_out_o = carry_out_q;

endmodule

// File: tb/tb_seq_addsub_n.sv
// Directed testbench for seq_addsub_n: three instances, one per overflow
// policy, share the same stimulus; expected values are hand-computed.
module tb_seq_addsub_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub_in = 1'b0;
    logic [15:0] a_in = 16'h0000;
    logic [15:0] b_in = 16'h0000;

    logic        busy0, done0, ovf0, cy0;
    logic        busy1, done1, ovf1, cy1;
    logic        busy2, done2, ovf2, cy2;
    logic [15:0] res0, res1, res2;

    int checks = 0;
    int failures = 0;

    seq_addsub_n #(.WIDTH(16), .CHUNK(4), .OVF_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .start_i(start), .sub_i(sub_in), .a_i(a_in), .b_i(b_in),
        .busy_o(busy0), .done_o(done0), .result_o(res0), .overflow_o(ovf0), .carry_out_o(cy0)
    );
    seq_addsub_n #(.WIDTH(16), .CHUNK(4), .OVF_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .start_i(start), .sub_i(sub_in), .a_i(a_in), .b_i(b_in),
        .busy_o(busy1), .done_o(done1), .result_o(res1), .overflow_o(ovf1), .carry_out_o(cy1)
    );
    seq_addsub_n #(.WIDTH(16), .CHUNK(4), .OVF_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .start_i(start), .sub_i(sub_in), .a_i(a_in), .b_i(b_in),
        .busy_o(busy2), .done_o(done2), .result_o(res2), .overflow_o(ovf2), .carry_out_o(cy2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation through all three instances; live inputs are scrambled after capture
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                          input logic eovf, input logic ecy);
        int cycles;
        int busy_cnt;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b; sub_in = s;
        @(negedge clk);
        start = 1'b0; a_in = 16'hA5A5; b_in = 16'h5A5A; sub_in = ~s;
        cycles = 1;
        busy_cnt = 0;
        while (done0 !== 1'b1 && cycles < 20) begin
            if (busy0 === 1'b1) busy_cnt++;
            @(negedge clk);
            cycles++;
        end
        chk({tag, "_latency"}, cycles, 5);
        chk({tag, "_busy_cycles"}, busy_cnt, 4);
        chk({tag, "_busy_at_done"}, {31'd0, busy0}, 32'd0);
        chk({tag, "_res_m0"}, {16'd0, res0}, {16'd0, e0});
        chk({tag, "_res_m1"}, {16'd0, res1}, {16'd0, e1});
        chk({tag, "_res_m2"}, {16'd0, res2}, {16'd0, e2});
        chk({tag, "_ovf"}, {29'd0, ovf0, ovf1, ovf2}, {29'd0, eovf, eovf, eovf});
        chk({tag, "_carry"}, {29'd0, cy0, cy1, cy2}, {29'd0, ecy, ecy, ecy});
        @(negedge clk);
        chk({tag, "_done_single"}, {31'd0, done0}, 32'd0);
        chk({tag, "_res_hold"}, {16'd0, res0}, {16'd0, e0});
    endtask

    logic [15:0] bb_a   [4] = '{16'h0100, 16'h1000, 16'h4000, 16'hFFFF};
    logic [15:0] bb_b   [4] = '{16'h0200, 16'h0001, 16'h4000, 16'h0001};
    logic        bb_s   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] bb_raw [4] = '{16'h0300, 16'h0FFF, 16'h8000, 16'h0000};
    logic [15:0] bb_m0  [4] = '{16'h0300, 16'h0FFF, 16'h0000, 16'h0000};

    initial begin
        int dn;
        logic [15:0] cap;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_result", {16'd0, res0}, 32'd0);
        chk("rst_flags", {30'd0, ovf0, cy0}, 32'd0);
        rst = 1'b0;

        // Plain add, positive overflow, subtracts
        run_op("add", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 16'h2221, 16'h2221, 1'b0, 1'b0);
        run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 16'h7FFF, 16'h8000, 1'b1, 1'b0);
        run_op("sub", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
        run_op("nsub", 16'h8000, 16'h0001, 1'b1, 16'h0000, 16'h8000, 16'h7FFF, 1'b1, 1'b1);

        // Start while busy is ignored and live inputs do not disturb the operation
        @(negedge clk);
        start = 1'b1; a_in = 16'h0001; b_in = 16'h0001; sub_in = 1'b0;
        @(negedge clk);
        a_in = 16'h00FF;
        @(negedge clk);
        a_in = 16'h0ABC; b_in = 16'h1111; sub_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        cap = 16'hDEAD;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) begin
                dn++;
                cap = res0;
            end
        end
        chk("busy_start_pulses", dn, 1);
        chk("busy_start_result", {16'd0, cap}, 32'h0002);

        // Reset in the second RUN cycle abandons the operation
        @(negedge clk);
        start = 1'b1; a_in = 16'h1111; b_in = 16'h2222; sub_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, busy0}, 32'd0);
        chk("midrst_result", {16'd0, res0}, 32'd0);
        chk("midrst_flags", {30'd0, ovf0, cy0}, 32'd0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) dn++;
        end
        chk("midrst_no_done", dn, 0);
        run_op("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 16'h0007, 16'h0007, 1'b0, 1'b0);

        // Back-to-back with start held high; operands change during RUN
        @(negedge clk);
        start = 1'b1; a_in = bb_a[0]; b_in = bb_b[0]; sub_in = bb_s[0];
        for (int j = 0; j < 4; j++) begin
            for (int c = 1; c <= 5; c++) begin
                @(negedge clk);
                if (c < 5) begin
                    chk($sformatf("b2b_%0d_nodone_%0d", j, c), {31'd0, done0}, 32'd0);
                    a_in = 16'hBEEF ^ 16'(c); b_in = 16'h7777; sub_in = 1'b1;
                end else begin
                    chk($sformatf("b2b_%0d_done", j), {31'd0, done0}, 32'd1);
                    chk($sformatf("b2b_%0d_raw", j), {16'd0, res2}, {16'd0, bb_raw[j]});
                    chk($sformatf("b2b_%0d_m0", j), {16'd0, res0}, {16'd0, bb_m0[j]});
                    if (j < 3) begin
                        a_in = bb_a[j+1]; b_in = bb_b[j+1]; sub_in = bb_s[j+1];
                    end else begin
                        start = 1'b0;
                    end
                end
            end
        end
        chk("b2b_last_carry", {31'd0, cy2}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
